uart_rx_periph: RTL and testbench

//  Memory-mapped UART receiver for the NoobsCPU data bus; receive-side counterpart of the UART TX peripheral.

---
 rtl/uart_rx_periph_pkg.sv | 17 +
 rtl/uart_rx_fifo.sv | 52 +++++
 rtl/uart_rx_periph.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_periph.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_periph_pkg.sv
// rtl/uart_rx_periph_pkg.sv - shared receiver state encodings, 8N1 oversample constants and default bus addresses
package uart_rx_periph_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

  localparam logic [3:0] OS_MID  = 4'd7;
  localparam logic [3:0] OS_LAST = 4'd15;

  localparam logic [10:0] RX_DATA_ADDR_DEF = 11'd102;
  localparam logic [10:0] RX_STAT_ADDR_DEF = 11'd103;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous receive FIFO; a push while full is taken only together with a pop
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // When full, wr_ptr aliases rd_ptr: the popped slot is reused by the new byte.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_periph.sv
// rtl/uart_rx_periph.sv - memory-mapped 8N1 UART receiver, 16x oversampling
// UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO instead of a single holding register.
module uart_rx_periph
  import uart_rx_periph_pkg::*;
#(
  parameter int          BAUD_DIV     = 27,
  parameter logic [10:0] RX_DATA_ADDR = RX_DATA_ADDR_DEF,
  parameter logic [10:0] RX_STAT_ADDR = RX_STAT_ADDR_DEF
`ifdef UART_RX_FIFO_EN
  , parameter int        FIFO_DEPTH   = 4
`endif
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        rx,
  input  logic [10:0] m_addr,
  input  logic        m_rd,
  input  logic        m_wr,
  input  logic        m_en,
  input  logic [7:0]  m_wr_data,
  output logic [7:0]  m_rd_data,
  output logic        rd_hit,
  output logic        rx_irq
);

  localparam logic [7:0] DIV_LAST = 8'(BAUD_DIV - 1);

  logic       rx_q1, rx_s;
  logic [7:0] div_cnt;
  logic       tick;
  rx_state_t  state, state_nxt;
  logic [3:0] os;
  logic [2:0] bi;
  logic [7:0] shift;
  logic       os_clr, os_inc, bi_clr, bi_inc, shift_en, push_req, frame_set;
  logic       rd_data_sel, rd_stat_sel, rd_data_q, wr_stat, pop;
  logic       valid, full, overrun_set;
  logic [7:0] head;
  logic       overrun, frame_err;
  logic [7:0] status;
  logic       unused_wr_bits;

  assign unused_wr_bits = ^{m_wr_data[7:3], m_wr_data[0]};

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) div_cnt <= 8'd0;
    else         div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
  end
  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!rx_s) state_nxt = ST_START;
      ST_START: if (tick && os == OS_MID) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:  if (tick && os == OS_LAST && bi == 3'd7) state_nxt = ST_STOP;
      ST_STOP:  if (tick && os == OS_LAST) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    os_clr    = 1'b0;
    os_inc    = 1'b0;
    bi_clr    = 1'b0;
    bi_inc    = 1'b0;
    shift_en  = 1'b0;
    push_req  = 1'b0;
    frame_set = 1'b0;
    case (state)
      ST_IDLE: os_clr = ~rx_s;
      ST_START: if (tick) begin
        if (os == OS_MID) begin
          os_clr = 1'b1;
          bi_clr = 1'b1;
        end else begin
          os_inc = 1'b1;
        end
      end
      ST_DATA: if (tick) begin
        os_inc = 1'b1;
        if (os == OS_LAST) begin
          shift_en = 1'b1;
          bi_inc   = 1'b1;
        end
      end
      ST_STOP: if (tick) begin
        os_inc = 1'b1;
        if (os == OS_LAST) begin
          push_req  = rx_s;
          frame_set = ~rx_s;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      os    <= 4'd0;
      bi    <= 3'd0;
      shift <= 8'd0;
    end else begin
      if (os_clr)      os <= 4'd0;
      else if (os_inc) os <= os + 4'd1;
      if (bi_clr)      bi <= 3'd0;
      else if (bi_inc) bi <= bi + 3'd1;
      if (shift_en)    shift <= {rx_s, shift[7:1]};
    end
  end

  assign rd_data_sel = m_en & m_rd & (m_addr == RX_DATA_ADDR);
  assign rd_stat_sel = m_en & m_rd & (m_addr == RX_STAT_ADDR);
  assign rd_hit      = rd_data_sel | rd_stat_sel;
  assign wr_stat     = m_en & m_wr & (m_addr == RX_STAT_ADDR);

  // Pop only on the first cycle of a data read, however long the strobe is held.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) rd_data_q <= 1'b0;
    else         rd_data_q <= rd_data_sel;
  end
  assign pop = rd_data_sel & ~rd_data_q & valid;

  assign overrun_set = push_req & full & ~pop;

`ifdef UART_RX_FIFO_EN
  logic fifo_empty;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .reset_ (reset_),
    .push   (push_req),
    .pop    (pop),
    .din    (shift),
    .dout   (head),
    .full   (full),
    .empty  (fifo_empty)
  );
  assign valid = ~fifo_empty;
`else
  logic [7:0] hold;
  logic       hold_valid;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      hold       <= 8'd0;
      hold_valid <= 1'b0;
    end else if (push_req && (!hold_valid || pop)) begin
      hold       <= shift;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
  assign head  = hold;
  assign valid = hold_valid;
  assign full  = hold_valid;
`endif

  // A flag being set wins over a W1C on the same cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (overrun_set)                   overrun <= 1'b1;
      else if (wr_stat && m_wr_data[1])  overrun <= 1'b0;
      if (frame_set)                     frame_err <= 1'b1;
      else if (wr_stat && m_wr_data[2])  frame_err <= 1'b0;
    end
  end

  assign status = {5'b0, frame_err, overrun, valid};
  assign rx_irq = valid;

  always_comb begin
    m_rd_data = 8'h00;
    if (rd_data_sel)      m_rd_data = valid ? head : 8'h00;
    else if (rd_stat_sel) m_rd_data = status;
  end

endmodule

// File: tb/tb_uart_rx_periph.sv
// tb/tb_uart_rx_periph.sv - directed bench for uart_rx_periph with BAUD_DIV=4 (64 clk per bit)
module tb_uart_rx_periph;

  localparam int          BIT_CLKS = 64;
  localparam logic [10:0] A_DATA   = 11'd102;
  localparam logic [10:0] A_STAT   = 11'd103;

  logic        clk = 1'b0;
  logic        reset_;
  logic        rx;
  logic [10:0] m_addr;
  logic        m_rd, m_wr, m_en;
  logic [7:0]  m_wr_data;
  logic [7:0]  m_rd_data;
  logic        rd_hit;
  logic        rx_irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_periph #(.BAUD_DIV(4)) dut (
    .clk       (clk),
    .reset_    (reset_),
    .rx        (rx),
    .m_addr    (m_addr),
    .m_rd      (m_rd),
    .m_wr      (m_wr),
    .m_en      (m_en),
    .m_wr_data (m_wr_data),
    .m_rd_data (m_rd_data),
    .rd_hit    (rd_hit),
    .rx_irq    (rx_irq)
  );

  typedef struct {
    logic [7:0] bval;
    logic       stop;
    logic [7:0] st1;
    logic [7:0] data;
    logic [7:0] st2;
    logic [7:0] clr;
    logic [7:0] st3;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A low stop bit is cut short so the line is high again before a false start's mid-bit check.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(BIT_CLKS);
    end
    rx = stop;
    idle(stop ? BIT_CLKS : 40);
    rx = 1'b1;
    idle(100);
  endtask

  task automatic read_check(input string name, input logic [10:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    logic       h;
    m_en = 1'b1; m_rd = 1'b1; m_addr = addr;
    #1;
    d = m_rd_data;
    h = rd_hit;
    @(negedge clk);
    m_en = 1'b0; m_rd = 1'b0;
    idle(1);
    check({name, " hit"}, {7'b0, h}, 8'h01);
    check(name, d, exp);
  endtask

  task automatic bus_write(input logic [10:0] addr, input logic [7:0] data);
    m_en = 1'b1; m_wr = 1'b1; m_addr = addr; m_wr_data = data;
    @(negedge clk);
    m_en = 1'b0; m_wr = 1'b0;
    idle(1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'h01, 8'hA5, 8'h00, 8'h00, 8'h00};
    vecs[1] = '{8'h3C, 1'b0, 8'h04, 8'h00, 8'h04, 8'h04, 8'h00};
    vecs[2] = '{8'h00, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00};
    vecs[4] = '{8'h81, 1'b1, 8'h01, 8'h81, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{8'h5A, 1'b0, 8'h04, 8'h00, 8'h04, 8'h06, 8'h00};

    reset_ = 1'b0; rx = 1'b1; m_addr = 11'd0; m_rd = 1'b0; m_wr = 1'b0; m_en = 1'b0; m_wr_data = 8'h00;
    idle(5);
    check("reset rd_data", m_rd_data, 8'h00);
    check("reset rd_hit", {7'b0, rd_hit}, 8'h00);
    check("reset irq", {7'b0, rx_irq}, 8'h00);
    reset_ = 1'b1;
    idle(5);
    read_check("reset stat", A_STAT, 8'h00);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].bval, vecs[i].stop);
      check($sformatf("v%0d irq", i), {7'b0, rx_irq}, {7'b0, vecs[i].st1[0]});
      read_check($sformatf("v%0d stat1", i), A_STAT, vecs[i].st1);
      read_check($sformatf("v%0d data", i), A_DATA, vecs[i].data);
      read_check($sformatf("v%0d stat2", i), A_STAT, vecs[i].st2);
      bus_write(A_STAT, vecs[i].clr);
      read_check($sformatf("v%0d stat3", i), A_STAT, vecs[i].st3);
    end

    // Short low pulse on an idle line
    rx = 1'b0;
    idle(20);
    rx = 1'b1;
    idle(100);
    check("glitch state", 8'(dut.state), 8'h00);
    check("glitch irq", {7'b0, rx_irq}, 8'h00);
    read_check("glitch stat", A_STAT, 8'h00);

    bus_write(A_DATA, 8'hFF);
    read_check("data write ignored", A_STAT, 8'h00);

`ifdef UART_RX_FIFO_EN
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    send_frame(8'h55, 1'b1);
    read_check("ovr stat", A_STAT, 8'h03);
    read_check("ovr d0", A_DATA, 8'h11);
    read_check("ovr d1", A_DATA, 8'h22);
    read_check("ovr d2", A_DATA, 8'h33);
    read_check("ovr d3", A_DATA, 8'h44);
    read_check("ovr stat2", A_STAT, 8'h02);
`else
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    read_check("ovr stat", A_STAT, 8'h03);
    read_check("ovr data", A_DATA, 8'h11);
    read_check("ovr stat2", A_STAT, 8'h02);
`endif
    bus_write(A_STAT, 8'h02);
    read_check("ovr clr", A_STAT, 8'h00);

    // Data read strobe held for three cycles
    send_frame(8'h66, 1'b1);
`ifdef UART_RX_FIFO_EN
    send_frame(8'h77, 1'b1);
`endif
    m_en = 1'b1; m_rd = 1'b1; m_addr = A_DATA;
    #1;
    check("hold cyc1", m_rd_data, 8'h66);
    @(negedge clk);
    #1;
`ifdef UART_RX_FIFO_EN
    check("hold cyc2", m_rd_data, 8'h77);
`else
    check("hold cyc2", m_rd_data, 8'h00);
`endif
    @(negedge clk);
    @(negedge clk);
    m_en = 1'b0; m_rd = 1'b0;
    idle(1);
`ifdef UART_RX_FIFO_EN
    read_check("hold stat", A_STAT, 8'h01);
    read_check("hold next", A_DATA, 8'h77);
`endif
    read_check("hold stat end", A_STAT, 8'h00);

    // Reset during bit 4 of a frame
    rx = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = vecs[5].bval[i];
      idle(BIT_CLKS);
    end
    rx = vecs[5].bval[4];
    idle(10);
    reset_ = 1'b0;
    rx = 1'b1;
    idle(5);
    reset_ = 1'b1;
    idle(100);
    check("rst state", 8'(dut.state), 8'h00);
    check("rst irq", {7'b0, rx_irq}, 8'h00);
    read_check("rst stat", A_STAT, 8'h00);
    send_frame(8'h5A, 1'b1);
    read_check("post rst stat", A_STAT, 8'h01);
    read_check("post rst data", A_DATA, 8'h5A);
    read_check("post rst stat2", A_STAT, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
